// File: rtl/core_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer_pkg / core_sequencer_if
// Brief    : Decoded-instruction type and the shared memory-port handshake.
// Revision : 1.0 - initial release
// ============================================================================
package core_sequencer_pkg;

    typedef enum logic [3:0] {
        OP          = 4'd0,
        OPIMM       = 4'd1,
        LOAD        = 4'd2,
        STORE       = 4'd3,
        BRANCH      = 4'd4,
        JAL         = 4'd5,
        JALR        = 4'd6,
        LUI         = 4'd7,
        AUIPC       = 4'd8,
        UNSUPPORTED = 4'd15
    } itype_e;

    typedef struct packed {
        itype_e     itype;
        logic       dst_valid;
        logic [4:0] dst;
    } DecodedInst;

endpackage

interface core_sequencer_if;
    logic mem_req_valid_out;
    logic mem_req_ready_in;
    logic mem_req_is_data_out;
    logic mem_req_write_out;
    logic mem_resp_valid_in;

    modport master (
        output mem_req_valid_out,
        output mem_req_is_data_out,
        output mem_req_write_out,
        input  mem_req_ready_in,
        input  mem_resp_valid_in
    );

    modport slave (
        input  mem_req_valid_out,
        input  mem_req_is_data_out,
        input  mem_req_write_out,
        output mem_req_ready_in,
        output mem_resp_valid_in
    );
endinterface
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Brief    : Multi-cycle RV32I control FSM and shared memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module core_sequencer
    import core_sequencer_pkg::*;
(
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    input  wire logic        start_in,
    input  wire logic        halt_req_in,
    input  wire DecodedInst  dinst,
    input  wire logic        br_taken_in,
    core_sequencer_if.master mem,
    output logic             ir_load_out,
    output logic             alu_a_sel_out,
    output logic             alu_b_sel_out,
    output logic [1:0]       wb_sel_out,
    output logic             rf_we_out,
    output logic             pc_we_out,
    output logic [1:0]       pc_sel_out,
    output logic             retire_out,
    output logic             trap_out,
    output logic [3:0]       state_out,
    output logic [31:0]      instret_out
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH_REQ  = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXECUTE    = 4'd4,
        S_MEM_REQ    = 4'd5,
        S_MEM_WAIT   = 4'd6,
        S_WRITEBACK  = 4'd7,
        S_TRAP       = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_store;
    logic [31:0] r_instret;

    // Store flag is latched so the request-phase outputs depend only on registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_instret  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXECUTE)
                r_is_store <= (dinst.itype == STORE);
            if (r_state == S_WRITEBACK)
                r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        w_next                  = r_state;
        mem.mem_req_valid_out   = 1'b0;
        mem.mem_req_is_data_out = 1'b0;
        mem.mem_req_write_out   = 1'b0;
        ir_load_out             = 1'b0;
        alu_a_sel_out           = 1'b0;
        alu_b_sel_out           = 1'b0;
        wb_sel_out              = 2'd0;
        rf_we_out               = 1'b0;
        pc_we_out               = 1'b0;
        pc_sel_out              = 2'd0;
        retire_out              = 1'b0;
        trap_out                = 1'b0;
        state_out               = r_state;
        instret_out             = r_instret;

        case (r_state)
            S_IDLE:       if (start_in) w_next = S_FETCH_REQ;
            S_FETCH_REQ: begin
                mem.mem_req_valid_out = 1'b1;
                if (mem.mem_req_ready_in) w_next = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                ir_load_out = mem.mem_resp_valid_in;
                if (mem.mem_resp_valid_in) w_next = S_DECODE;
            end
            S_DECODE:     w_next = (dinst.itype == UNSUPPORTED) ? S_TRAP : S_EXECUTE;
            S_EXECUTE:    w_next = (dinst.itype == LOAD || dinst.itype == STORE) ? S_MEM_REQ : S_WRITEBACK;
            S_MEM_REQ: begin
                mem.mem_req_valid_out   = 1'b1;
                mem.mem_req_is_data_out = 1'b1;
                mem.mem_req_write_out   = r_is_store;
                if (mem.mem_req_ready_in) w_next = S_MEM_WAIT;
            end
            S_MEM_WAIT:   if (mem.mem_resp_valid_in) w_next = S_WRITEBACK;
            S_WRITEBACK: begin
                pc_we_out  = 1'b1;
                retire_out = 1'b1;
                rf_we_out  = dinst.dst_valid && (dinst.dst != 5'd0);
                w_next     = halt_req_in ? S_IDLE : S_FETCH_REQ;
            end
            S_TRAP:       trap_out = 1'b1;
            default:      w_next = S_IDLE;
        endcase

        // Datapath selects are held at zero outside the decode..writeback window.
        if (r_state >= S_DECODE && r_state <= S_WRITEBACK) begin
            case (dinst.itype)
                BRANCH: pc_sel_out = br_taken_in ? 2'd1 : 2'd0;
                OPIMM:  alu_b_sel_out = 1'b1;
                LOAD: begin
                    alu_b_sel_out = 1'b1;
                    wb_sel_out    = 2'd1;
                end
                STORE:  alu_b_sel_out = 1'b1;
                JAL: begin
                    wb_sel_out = 2'd2;
                    pc_sel_out = 2'd1;
                end
                JALR: begin
                    alu_b_sel_out = 1'b1;
                    wb_sel_out    = 2'd2;
                    pc_sel_out    = 2'd2;
                end
                LUI:    wb_sel_out = 2'd3;
                AUIPC: begin
                    alu_a_sel_out = 1'b1;
                    alu_b_sel_out = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the RV32I core. It steps each instruction through fetch, decode, execute, optional memory access and writeback, and drives all datapath selects from the `DecodedInst` produced by the decoder on the instruction register. It also arbitrates the core's single shared memory port between instruction fetch and load/store traffic, using a valid/ready request and response handshake. It traps on any instruction that decodes as `Unsupported`.

## Interface
- No parameters.
- `clk_in`  in  1  system clock; all state changes on rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `start_in`  in  1  leave IDLE and begin fetching.
- `halt_req_in`  in  1  return to IDLE after the current instruction retires.
- `dinst`  in  DecodedInst  decoder output for the current IR; valid from DECODE until WRITEBACK.
- `br_taken_in`  in  1  branch-compare result for the current BRANCH.
- `mem_req_valid_out`  out  1  memory request valid.
- `mem_req_ready_in`  in  1  memory accepts the request.
- `mem_req_is_data_out`  out  1  0 = instruction fetch (address = PC); 1 = load/store (address = ALU result).
- `mem_req_write_out`  out  1  store request.
- `mem_resp_valid_in`  in  1  read data valid / store acknowledge.
- `ir_load_out`  out  1  capture the fetched word into IR.
- `alu_a_sel_out`  out  1  0 = rs1, 1 = PC.
- `alu_b_sel_out`  out  1  0 = rs2, 1 = imm.
- `wb_sel_out`  out  2  0 = ALU, 1 = memory, 2 = PC+4, 3 = imm.
- `rf_we_out`  out  1  register-file write enable.
- `pc_we_out`  out  1  PC write enable.
- `pc_sel_out`  out  2  0 = PC+4, 1 = PC+imm, 2 = {alu[31:1],1'b0}.
- `retire_out`  out  1  one-cycle pulse per retired instruction.
- `trap_out`  out  1  sticky trap flag.
- `state_out`  out  4  current state encoding.
- `instret_out`  out  32  retired-instruction count.

## Operation
- State encodings: IDLE=0, FETCH_REQ=1, FETCH_WAIT=2, DECODE=3, EXECUTE=4, MEM_REQ=5, MEM_WAIT=6, WRITEBACK=7, TRAP=8.
- IDLE -> FETCH_REQ when `start_in` is high.
- FETCH_REQ: assert `mem_req_valid_out` with is_data=0 and write=0. Move to FETCH_WAIT on `mem_req_ready_in`. Valid is held until accepted.
- FETCH_WAIT: when `mem_resp_valid_in` is high, assert `ir_load_out` in that same cycle and move to DECODE.
- DECODE -> TRAP if `dinst.itype` is `Unsupported`; otherwise -> EXECUTE.
- EXECUTE -> MEM_REQ for LOAD/STORE; all other types -> WRITEBACK.
- MEM_REQ: assert `mem_req_valid_out` with is_data=1 and write=(itype==STORE). Move to MEM_WAIT on ready.
- MEM_WAIT: move to WRITEBACK on `mem_resp_valid_in`. A store waits for its acknowledge before retiring.
- WRITEBACK:
  - `pc_we_out`=1 and `retire_out`=1; `instret_out` increments (wraps at 2^32).
  - Next state is IDLE if `halt_req_in` is high, else FETCH_REQ.
- `rf_we_out` = `dinst.dst_valid` && `dinst.dst` != 0, asserted in WRITEBACK only.
- TRAP: `trap_out`=1. All enables and requests are 0. Only reset exits TRAP.
- ALU operand selects, by itype:
  - OP, BRANCH: rs1, rs2.
  - OPIMM, LOAD, STORE, JALR: rs1, imm.
  - AUIPC: PC, imm.
- Writeback select, by itype: OP/OPIMM/AUIPC = ALU; LOAD = memory; JAL/JALR = PC+4; LUI = imm.
- PC select, by itype: JAL = 1; BRANCH = 1 if `br_taken_in`, else 0; JALR = 2; all others = 0.
- Select outputs are combinational from state and `dinst`; they are don't-care outside DECODE..WRITEBACK.
- `mem_resp_valid_in` is ignored outside FETCH_WAIT and MEM_WAIT.
- `halt_req_in` is sampled only in WRITEBACK.
- `start_in` is ignored outside IDLE.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `instret_out` = 0.
  - Every 1-bit output = 0; every select output = 0.
- Reset asserted mid-transaction abandons any outstanding memory request. The memory side is reset on the same `rst_in`.
- Outputs `mem_req_valid_out`, `mem_req_is_data_out`, `mem_req_write_out`, `retire_out`, `pc_we_out`, `trap_out` and `state_out` are Moore (decoded from registered state only).
- `ir_load_out` is Mealy: FETCH_WAIT && `mem_resp_valid_in`.
- Minimum latency, with ready high during the request and response one cycle after acceptance:
  - ALU, branch, jump, LUI, AUIPC: 5 cycles from FETCH_REQ entry to WRITEBACK exit.
  - LOAD, STORE: 7 cycles.
- Each cycle of ready-low or response delay extends the corresponding state by exactly one cycle.
- At most one memory request is outstanding at any time. A fetch and a data access are never requested in the same cycle.
- A response arriving in the same cycle as acceptance is not allowed; the memory returns it no earlier than the following cycle.

## Test plan
- Reset, then `start_in`=1 for one cycle with an always-ready memory returning ADDI x1,x0,5 (0x00500093) -> states 1,2,3,4,7; `rf_we_out`=1, `wb_sel_out`=0, `alu_b_sel_out`=1; `retire_out` one pulse; `instret_out`=1.
- LW x2,0(x1) with the data response delayed 3 cycles -> `mem_req_is_data_out`=1 and write=0 in MEM_REQ; MEM_WAIT lasts 4 cycles; `wb_sel_out`=1; `rf_we_out`=1 in WRITEBACK.
- BEQ with `br_taken_in`=1, then again with 0 -> `pc_sel_out`=1 then 0; `rf_we_out`=0 in both; `pc_we_out`=1 in both.
- Fetch word 0xFFFFFFFF (decodes as Unsupported) -> DECODE then TRAP; `trap_out` stays high and no memory requests are issued for 20 cycles; `rst_in` clears it.
- Hold `mem_req_ready_in`=0 for 5 cycles during FETCH_REQ -> `mem_req_valid_out` stays high throughout; pulse `rst_in` mid-wait -> IDLE immediately and all outputs 0.
- ADDI x0,x0,1 with `halt_req_in`=1 -> `rf_we_out`=0 because dst is x0; state returns to IDLE after WRITEBACK; `instret_out` increments.
